// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer. The optional feature
// macro STORE_BUFFER_FWD_EN is consumed in store_buffer.sv.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // Which client owns the shared dmem port in a given cycle
  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOAD,
    PORT_DRAIN
  } port_use_e;

endpackage

// File: rtl/store_buffer_match.sv
// Parallel word-address compare of a core address against buffered stores;
// reports a hit and the index of the youngest matching entry.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int WAW   = SB_AW - 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH*WAW-1:0] entry_waddr,
  input  logic [DEPTH-1:0]     entry_valid,
  input  logic [PW-1:0]        head,
  input  logic [WAW-1:0]       key,
  output logic                 hit,
  output logic [PW-1:0]        hit_idx
);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest so a later match overrides an earlier one
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entry_valid[idx] && (entry_waddr[int'(idx)*WAW +: WAW] == key)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between core data port and dmem with load-hit handling.
// Define STORE_BUFFER_FWD_EN to forward load hits instead of stalling.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     core_we,
  input  logic                     core_re,
  input  logic [AW-1:0]            core_addr,
  input  logic [DW-1:0]            core_wd,
  output logic [DW-1:0]            core_rd,
  output logic                     stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wd,
  input  logic [DW-1:0]            mem_rd,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WAW = AW - 2;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [AW-1:0]        addr_q  [DEPTH];
  logic [DW-1:0]        data_q  [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;
  logic [PW:0]          count_q;

  logic [DEPTH*WAW-1:0] entry_waddr;
  logic                 match_hit;
  logic [PW-1:0]        hit_idx;
  logic                 load_hit;
  logic                 full;
  logic                 enq;
  logic                 deq;
  port_use_e            port_use;

  always_comb begin
    entry_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_waddr[i*WAW +: WAW] = addr_q[i][AW-1:2];
    end
  end

  store_buffer_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW)
  ) u_match (
    .entry_waddr (entry_waddr),
    .entry_valid (valid_q),
    .head        (head_q),
    .key         (core_addr[AW-1:2]),
    .hit         (match_hit),
    .hit_idx     (hit_idx)
  );

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign load_hit = core_re && match_hit;
  assign enq      = core_we && !full;
  assign deq      = (port_use == PORT_DRAIN);

  // A missing load owns the port; otherwise drain, but never while reset is
  // asserted so discarded entries cannot leak into dmem.
  always_comb begin
    port_use = PORT_IDLE;
    if (core_re && !match_hit) begin
      port_use = PORT_LOAD;
    end else if (!empty && reset) begin
      port_use = PORT_DRAIN;
    end

    mem_we   = (port_use == PORT_DRAIN);
    mem_addr = (port_use == PORT_DRAIN) ? addr_q[head_q] : core_addr;
    mem_wd   = data_q[head_q];

    core_rd  = (FWD_EN && load_hit) ? data_q[hit_idx] : mem_rd;
    stall    = (core_we && full) || (!FWD_EN && load_hit && !core_we);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (enq && !deq) begin
        count_q <= count_q + 1'b1;
      end else if (deq && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Payload storage needs no reset; valid_q qualifies every entry
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= core_addr;
      data_q[tail_q] <= core_wd;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based model compared every
// cycle plus directed literal checks; honours STORE_BUFFER_FWD_EN.
module tb_store_buffer;

  localparam int DEPTH = 4;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        empty;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .core_we   (core_we),
    .core_re   (core_re),
    .core_addr (core_addr),
    .core_wd   (core_wd),
    .core_rd   (core_rd),
    .stall     (stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .empty     (empty),
    .count     (count)
  );

  function automatic logic [31:0] seed(int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010001);
  endfunction

  // Bench-side dmem with asynchronous read, plus a log of every write it sees
  logic [31:0] dmem [0:1023];
  bit          dmem_init = 1'b0;
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];

  always_comb mem_rd = dmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (!dmem_init) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= seed(i);
      dmem_init <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr[11:2]] <= mem_wd;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wd);
    end
  end

  // Reference model: an ordered list of pending stores and an image of dmem
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] mmem [0:1023];
  bit          mmem_init  = 1'b0;
  bit          seen_reset = 1'b0;

  function automatic bit mhit(logic [31:0] a);
    bit h = 1'b0;
    foreach (mq[i]) if (mq[i].a[31:2] == a[31:2]) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] myoungest(logic [31:0] a);
    logic [31:0] d = '0;
    foreach (mq[i]) if (mq[i].a[31:2] == a[31:2]) d = mq[i].d;
    return d;
  endfunction

  function automatic bit mdrain();
    return reset && (mq.size() > 0) && !(core_re && !mhit(core_addr));
  endfunction

  always @(posedge clk) begin
    bit dr;
    bit fl;
    if (!mmem_init) begin
      for (int i = 0; i < 1024; i++) mmem[i] = seed(i);
      mmem_init = 1'b1;
    end
    if (!reset) begin
      mq.delete();
      seen_reset = 1'b1;
    end else begin
      dr = mdrain();
      fl = (mq.size() == DEPTH);
      if (dr) begin
        mmem[mq[0].a[11:2]] = mq[0].d;
        void'(mq.pop_front());
      end
      if (core_we && !fl) mq.push_back('{a: core_addr, d: core_wd});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit hit;
    bit dr;
    bit fl;
    if (seen_reset) begin
      hit = core_re && mhit(core_addr);
      dr  = mdrain();
      fl  = (mq.size() == DEPTH);
      checkOutput("cyc_count", 32'(count), 32'(mq.size()));
      checkOutput("cyc_empty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("cyc_stall", 32'(stall), 32'((core_we && fl) || (!FWD && hit && !core_we)));
      checkOutput("cyc_mem_we", 32'(mem_we), 32'(dr));
      checkOutput("cyc_mem_addr", mem_addr, dr ? mq[0].a : core_addr);
      if (dr) checkOutput("cyc_mem_wd", mem_wd, mq[0].d);
      if (core_re && !core_we && !hit) checkOutput("cyc_core_rd", core_rd, mmem[core_addr[11:2]]);
`ifdef STORE_BUFFER_FWD_EN
      if (core_re && !core_we && hit) checkOutput("cyc_core_rd_fwd", core_rd, myoungest(core_addr));
`endif
    end
  end

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd);
    core_we   = we;
    core_re   = re;
    core_addr = addr;
    core_wd   = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input int budget);
    for (int n = 0; n < budget && !empty; n++) tick();
    checkOutput("drain_done", 32'(empty), 32'd1);
  endtask

  initial begin
    int base;

    // Reset held two cycles while a store is requested
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h99);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    tick();

    // Single store drains the following cycle
    applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("single_mem_we", 32'(mem_we), 32'd1);
    checkOutput("single_mem_addr", mem_addr, 32'h10);
    checkOutput("single_mem_wd", mem_wd, 32'hDEADBEEF);
    tick();
    checkOutput("single_empty", 32'(empty), 32'd1);
    checkOutput("single_log", wlog_d[wlog_d.size()-1], 32'hDEADBEEF);

    // Fill while loads occupy the port, then overflow attempt
    base = wlog_a.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'h110, 32'hA4);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("full_not_enq", 32'(count), 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitEmpty(10);
    checkOutput("full_nwrites", 32'(wlog_a.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < wlog_a.size(); i++) begin
      checkOutput("full_order_a", wlog_a[base+i], 32'h100 + 32'(4*i));
      checkOutput("full_order_d", wlog_d[base+i], 32'hA0 + 32'(i));
    end

    // Load hitting buffered stores to the same word
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h1111);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h2222);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
    checkOutput("hit_fwd_rd", core_rd, 32'h2222);
    checkOutput("hit_fwd_stall", 32'(stall), 32'd0);
`else
    checkOutput("hit_stall", 32'(stall), 32'd1);
`endif
    tick();
    checkOutput("hit_done_stall", 32'(stall), 32'd0);
    checkOutput("hit_done_rd", core_rd, 32'h2222);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitEmpty(10);

    // Two buffered stores to one word: the younger one must win
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h5555);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h3333);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h6666);
    tick();
    checkOutput("young_count", 32'(count), 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h30, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
    checkOutput("young_fwd_rd", core_rd, 32'h6666);
`else
    checkOutput("young_stall", 32'(stall), 32'd1);
`endif
    tick();
    tick();
    checkOutput("young_done_stall", 32'(stall), 32'd0);
    checkOutput("young_done_rd", core_rd, 32'h6666);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitEmpty(10);

    // Ten stores streaming through the pointer wrap
    base = wlog_a.size();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(4*i), 32'h500 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitEmpty(10);
    checkOutput("wrap_nwrites", 32'(wlog_a.size() - base), 32'd10);
    for (int i = 0; i < 10 && base + i < wlog_a.size(); i++) begin
      checkOutput("wrap_order_a", wlog_a[base+i], 32'(4*i));
      checkOutput("wrap_order_d", wlog_d[base+i], 32'h500 + 32'(i));
    end

    // Reset with entries pending discards them
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h200 + 32'(4*i), 32'h700 + 32'(i));
      tick();
    end
    checkOutput("midrst_count_pre", 32'(count), 32'd3);
    base = wlog_a.size();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_nwrites", 32'(wlog_a.size() - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
